// File: rtl/mac_seq_pkg.sv
// ----------------------------------------------------------------------------
// mac_seq_pkg
// Shared definitions for the dot-product MAC sequencer:
//   - state_t   : FSM state encoding (IDLE=0, ACC=1, DONE=2)
//   - DEF_W     : default operand width W (accumulator is 2W)
//   - DEF_LEN_W : default width of the vector-length field
// ----------------------------------------------------------------------------
package mac_seq_pkg;

    localparam int DEF_W     = 16;
    localparam int DEF_LEN_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mac_dot_seq_mac.sv
// ----------------------------------------------------------------------------
// conf_int_mac__noFF__arch_agnos
// Purely combinational unsigned integer MAC: d = a*b + c_in (mod 2^(2W)).
// Holds no state.
// Ports:
//   a, b  in  W   operands
//   c_in  in  2W  addend (accumulator feedback)
//   d     out 2W  a*b + c_in, wrapped to 2W bits
// ----------------------------------------------------------------------------
module conf_int_mac__noFF__arch_agnos #(
    parameter int OP_BITWIDTH        = 16,
    parameter int DATA_PATH_BITWIDTH = 16
) (
    input  logic [DATA_PATH_BITWIDTH-1:0]   a,
    input  logic [DATA_PATH_BITWIDTH-1:0]   b,
    input  logic [2*DATA_PATH_BITWIDTH-1:0] c_in,
    output logic [2*DATA_PATH_BITWIDTH-1:0] d
);

    localparam int PROD_W = 2 * OP_BITWIDTH;
    localparam int ACC_W  = 2 * DATA_PATH_BITWIDTH;

    logic [OP_BITWIDTH-1:0] a_op;
    logic [OP_BITWIDTH-1:0] b_op;
    logic [PROD_W-1:0]      prod;

    // The multiplier is sized by the operator width; operands are resized onto it.
    assign a_op = OP_BITWIDTH'(a);
    assign b_op = OP_BITWIDTH'(b);
    assign prod = PROD_W'(a_op) * PROD_W'(b_op);
    assign d    = ACC_W'(prod) + c_in;

endmodule

// File: rtl/mac_dot_seq.sv
// ----------------------------------------------------------------------------
// mac_dot_seq
// Sequencer driving one shared combinational MAC to compute an unsigned dot
// product of `len` operand pairs. The accumulator is fed back into c_in on
// every accepted beat and the final sum is offered on a result handshake.
// Ports:
//   clk, rst           clock (rising edge) / asynchronous active-low reset
//   start, len         command strobe and pair count (sampled in IDLE only)
//   busy               high while in ACC or DONE
//   in_valid, in_ready operand-pair handshake; a, b are the operands
//   out_valid,out_ready result handshake; result is the 2W-bit sum
//   beat_cnt           pairs remaining in the current command
//   sat                (MAC_DOT_SAT_EN only) sticky saturation flag
// Optional feature: define MAC_DOT_SAT_EN to saturate the accumulator at
// 2^(2W)-1 instead of wrapping, and to add the sat output.
// ----------------------------------------------------------------------------
module mac_dot_seq
    import mac_seq_pkg::*;
#(
    parameter int OP_BITWIDTH        = DEF_W,
    parameter int DATA_PATH_BITWIDTH = DEF_W,
    parameter int LEN_W              = DEF_LEN_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [LEN_W-1:0]                len,
    output logic                            busy,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_PATH_BITWIDTH-1:0]   a,
    input  logic [DATA_PATH_BITWIDTH-1:0]   b,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [2*DATA_PATH_BITWIDTH-1:0] result,
    output logic [LEN_W-1:0]                beat_cnt
`ifdef MAC_DOT_SAT_EN
    ,
    output logic                            sat
`endif
);

    localparam int ACC_W = 2 * DATA_PATH_BITWIDTH;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [ACC_W-1:0]  acc_next;
    logic              fire;
`ifdef MAC_DOT_SAT_EN
    logic              sat_q, sat_d;
    logic              ovf;
`endif

    conf_int_mac__noFF__arch_agnos #(
        .OP_BITWIDTH        (OP_BITWIDTH),
        .DATA_PATH_BITWIDTH (DATA_PATH_BITWIDTH)
    ) u_mac (
        .a    (a),
        .b    (b),
        .c_in (acc_q),
        .d    (acc_next)
    );

    // in_ready_q is high exactly in ACC, so it doubles as the state qualifier.
    assign fire = in_valid & in_ready_q;

`ifdef MAC_DOT_SAT_EN
    // The product never reaches 2^(2W), so a wrapped sum is always below acc.
    assign ovf = (acc_next < acc_q);
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
`ifdef MAC_DOT_SAT_EN
        sat_d   = sat_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    cnt_d   = len;
`ifdef MAC_DOT_SAT_EN
                    sat_d   = 1'b0;
`endif
                    state_d = (len == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                if (fire) begin
`ifdef MAC_DOT_SAT_EN
                    if (sat_q || ovf) begin
                        acc_d = '1;
                        sat_d = 1'b1;
                    end else begin
                        acc_d = acc_next;
                    end
`else
                    acc_d = acc_next;
`endif
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Moore outputs are decoded from the next state so they register alongside it.
        busy_d      = (state_d != IDLE);
        in_ready_d  = (state_d == ACC);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef MAC_DOT_SAT_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef MAC_DOT_SAT_EN
            sat_q       <= sat_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = acc_q;
    assign beat_cnt  = cnt_q;
`ifdef MAC_DOT_SAT_EN
    assign sat       = sat_q;
`endif

endmodule

// File: tb/tb_mac_dot_seq.sv
// ----------------------------------------------------------------------------
// tb_mac_dot_seq
// Directed testbench for mac_dot_seq: reset, back-to-back beats, bubbles,
// empty command, wrap/saturation, result back-pressure with ignored start,
// and asynchronous reset mid-command.
// ----------------------------------------------------------------------------
module tb_mac_dot_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [7:0]  beat_cnt;
`ifdef MAC_DOT_SAT_EN
    logic        sat;
`endif

    int checks = 0;
    int errors = 0;

    mac_dot_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .beat_cnt  (beat_cnt)
`ifdef MAC_DOT_SAT_EN
        ,
        .sat       (sat)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a start strobe for one cycle.
    task automatic do_start(input logic [7:0] n);
        start = 1'b1;
        len   = n;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (result !== 32'd0) begin errors++; $display("[TB] FAIL reset_result: got %0h expected 0", result); end
        checks++; if (beat_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_beat_cnt: got %0d expected 0", beat_cnt); end
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] av [3];
        logic [15:0] bv [3];
        av = '{16'd2, 16'd4, 16'd6};
        bv = '{16'd3, 16'd5, 16'd7};
        out_ready = 1'b1;
        do_start(8'd3);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy: got %0b expected 1", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready: got %0b expected 1", in_ready); end
        checks++; if (beat_cnt !== 8'd3) begin errors++; $display("[TB] FAIL b2b_beat_cnt_start: got %0d expected 3", beat_cnt); end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = av[i];
            b = bv[i];
            tick();
            if (i < 2) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_early_valid beat %0d: got %0b expected 0", i, out_valid); end
                checks++; if (beat_cnt !== 8'(2 - i)) begin errors++; $display("[TB] FAIL b2b_beat_cnt beat %0d: got %0d expected %0d", i, beat_cnt, 2 - i); end
            end
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_out_valid: got %0b expected 1", out_valid); end
        checks++; if (result !== 32'd68) begin errors++; $display("[TB] FAIL b2b_result: got %0d expected 68", result); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_in_ready: got %0b expected 0", in_ready); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy_drop: got %0b expected 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_valid_drop: got %0b expected 0", out_valid); end
        checks++; if (result !== 32'd68) begin errors++; $display("[TB] FAIL b2b_result_held: got %0d expected 68", result); end
    endtask

    task automatic test_bubbles();
        int exp_cnt;
        out_ready = 1'b0;
        do_start(8'd4);
        exp_cnt = 4;
        for (int i = 0; i < 7; i++) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bub_in_ready cycle %0d: got %0b expected 1", i, in_ready); end
            checks++; if (beat_cnt !== 8'(exp_cnt)) begin errors++; $display("[TB] FAIL bub_beat_cnt cycle %0d: got %0d expected %0d", i, beat_cnt, exp_cnt); end
            in_valid = (i % 2 == 0);
            a = 16'd1;
            b = 16'd1;
            tick();
            if (i % 2 == 0) exp_cnt--;
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bub_out_valid: got %0b expected 1", out_valid); end
        checks++; if (result !== 32'd4) begin errors++; $display("[TB] FAIL bub_result: got %0d expected 4", result); end
        checks++; if (beat_cnt !== 8'd0) begin errors++; $display("[TB] FAIL bub_beat_cnt_end: got %0d expected 0", beat_cnt); end
        out_ready = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL bub_idle: got %0b expected 0", busy); end
    endtask

    task automatic test_len_zero();
        out_ready = 1'b0;
        do_start(8'd0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL zero_out_valid: got %0b expected 1", out_valid); end
        checks++; if (result !== 32'd0) begin errors++; $display("[TB] FAIL zero_result: got %0d expected 0", result); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL zero_in_ready: got %0b expected 0", in_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL zero_busy: got %0b expected 1", busy); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL zero_valid_drop: got %0b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL zero_in_ready_after: got %0b expected 0", in_ready); end
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        do_start(8'd2);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            a = 16'hFFFF;
            b = 16'hFFFF;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL wrap_out_valid: got %0b expected 1", out_valid); end
`ifdef MAC_DOT_SAT_EN
        checks++; if (result !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL sat_result: got %0h expected ffffffff", result); end
        checks++; if (sat !== 1'b1) begin errors++; $display("[TB] FAIL sat_flag: got %0b expected 1", sat); end
`else
        checks++; if (result !== 32'hFFFC0002) begin errors++; $display("[TB] FAIL wrap_result: got %0h expected fffc0002", result); end
`endif
        tick();
    endtask

    task automatic test_hold_done();
        out_ready = 1'b0;
        do_start(8'd1);
        in_valid = 1'b1;
        a = 16'd10;
        b = 16'd10;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_out_valid cycle %0d: got %0b expected 1", i, out_valid); end
            checks++; if (result !== 32'd100) begin errors++; $display("[TB] FAIL hold_result cycle %0d: got %0d expected 100", i, result); end
            start = (i == 2);
            len   = 8'd3;
            tick();
        end
        start = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_still_done: got %0b expected 1", out_valid); end
        checks++; if (beat_cnt !== 8'd0) begin errors++; $display("[TB] FAIL hold_start_ignored: got %0d expected 0", beat_cnt); end
`ifdef MAC_DOT_SAT_EN
        checks++; if (sat !== 1'b0) begin errors++; $display("[TB] FAIL sat_cleared: got %0b expected 0", sat); end
`endif
        out_ready = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL hold_release_idle: got %0b expected 0", busy); end
        do_start(8'd1);
        in_valid = 1'b1;
        a = 16'd3;
        b = 16'd3;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_next_valid: got %0b expected 1", out_valid); end
        checks++; if (result !== 32'd9) begin errors++; $display("[TB] FAIL hold_next_result: got %0d expected 9", result); end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        do_start(8'd5);
        in_valid = 1'b1;
        a = 16'd1; b = 16'd2;
        tick();
        a = 16'd3; b = 16'd4;
        tick();
        checks++; if (beat_cnt !== 8'd3) begin errors++; $display("[TB] FAIL mid_beat_cnt: got %0d expected 3", beat_cnt); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_busy: got %0b expected 0", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_in_ready: got %0b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_out_valid: got %0b expected 0", out_valid); end
        checks++; if (result !== 32'd0) begin errors++; $display("[TB] FAIL mid_rst_result: got %0d expected 0", result); end
        checks++; if (beat_cnt !== 8'd0) begin errors++; $display("[TB] FAIL mid_rst_beat_cnt: got %0d expected 0", beat_cnt); end
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_partial: got %0b expected 0", out_valid); end
        do_start(8'd1);
        in_valid = 1'b1;
        a = 16'd7;
        b = 16'd8;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_fresh_valid: got %0b expected 1", out_valid); end
        checks++; if (result !== 32'd56) begin errors++; $display("[TB] FAIL mid_fresh_result: got %0d expected 56", result); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_fresh_idle: got %0b expected 0", busy); end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = 8'd0;
        in_valid  = 1'b0;
        a         = 16'd0;
        b         = 16'd0;
        out_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_bubbles();
        test_len_zero();
        test_wrap();
        test_hold_done();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
